uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between NUM_REQ byte producers (status reporter, echo path, debug, ...).

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with per-owner message locking (capped at MAX_BURST bytes) and a hung-transmitter watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int TIMEOUT_CLKS = 125004
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_lock,
  input  logic [8*NUM_REQ-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_byte,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int OWN_W   = $clog2(NUM_REQ);
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int WD_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [7:0]         byte_q, byte_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] ack_c;
  logic [7:0]         data_arr [NUM_REQ];
  logic               win_found;
  logic [OWN_W-1:0]   win_idx;
  logic [OWN_W-1:0]   cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_arr[g] = i_data[8*g +: 8];
  end

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OWN_W'((int'(owner_q) + i) % NUM_REQ);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    byte_d    = byte_q;
    burst_d   = burst_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    ack_c     = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !i_tx_active) begin
          owner_d        = win_idx;
          byte_d         = data_arr[win_idx];
          ack_c[win_idx] = 1'b1;
          burst_d        = '0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        if (i_tx_done) begin
          if (i_lock[owner_q] && i_req[owner_q] && (burst_q < BURST_LAST)) begin
            byte_d         = data_arr[owner_q];
            ack_c[owner_q] = 1'b1;
            burst_d        = burst_q + 1'b1;
            state_d        = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_W'(NUM_REQ - 1);
      byte_q    <= '0;
      burst_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      byte_q    <= byte_d;
      burst_q   <= burst_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Ack is a same-cycle grant; masking with reset keeps it low while reset is held.
  assign o_ack      = ack_c & {NUM_REQ{i_rst_n}};
  assign o_owner    = owner_q;
  assign o_tx_start = (state_q == ISSUE);
  assign o_tx_byte  = byte_q;
  assign o_busy     = (state_q != IDLE);
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of grant-order vectors plus hand sequences for
// locking bursts, watchdog, transmitter-busy hold-off and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int MB  = 16;
  localparam int TO  = 64;
  localparam int DLY = 20;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req, i_lock, o_ack;
  logic [31:0] i_data;
  logic [1:0]  o_owner;
  logic        o_tx_start;
  logic [7:0]  o_tx_byte;
  logic        i_tx_active, i_tx_done, o_busy, o_timeout;

  logic [7:0]  dbyte [4];
  logic        m_active, m_done, f_active, model_en;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit         do_rst;
    logic [3:0] req;
    int         exp_idx;
  } vec_t;
  vec_t tbl [9];

  assign i_data      = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};
  assign i_tx_active = m_active | f_active;
  assign i_tx_done   = m_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_lock(i_lock), .i_data(i_data),
    .o_ack(o_ack), .o_owner(o_owner), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: done pulse DLY clocks after the start pulse.
  initial begin
    m_active = 1'b0;
    m_done   = 1'b0;
    m_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!i_rst_n) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        m_cnt    = 0;
      end else begin
        m_done = 1'b0;
        if (o_tx_start) begin
          m_cnt    = DLY;
          m_active = model_en;
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_active = 1'b0;
            m_done   = model_en;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input string nm, output logic [3:0] a);
    a = '0;
    for (int n = 0; n < 300 && a == 4'b0; n++) begin
      @(negedge clk);
      a = o_ack;
    end
    if (a == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_ack required=ack_within_300", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk);
      idle = !o_busy;
    end
    chk(nm, 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    i_rst_n  = 1'b0;
    i_req    = '0;
    i_lock   = '0;
    f_active = 1'b0;
    #1;
    chk("rst_busy",    32'(o_busy),     32'd0);
    chk("rst_start",   32'(o_tx_start), 32'd0);
    chk("rst_ack",     32'(o_ack),      32'd0);
    chk("rst_owner",   32'(o_owner),    32'd3);
    chk("rst_byte",    32'(o_tx_byte),  32'd0);
    chk("rst_timeout", 32'(o_timeout),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Expects a grant to exp_idx, then the start pulse exactly one clock later.
  task automatic serve(input string nm, input int exp_idx, input logic [7:0] exp_byte,
                       input logic [3:0] req_after);
    logic [3:0] a;
    wait_ack({nm, "_ack"}, a);
    chk({nm, "_ack"}, 32'(a), 32'(1 << exp_idx));
    @(posedge clk);
    #1;
    i_req = req_after;
    @(negedge clk);
    chk({nm, "_start"}, 32'(o_tx_start), 32'd1);
    chk({nm, "_byte"},  32'(o_tx_byte),  32'(exp_byte));
    chk({nm, "_owner"}, 32'(o_owner),    32'(exp_idx));
    chk({nm, "_noack_issue"}, 32'(o_ack), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    tbl[0] = '{1'b1, 4'b0101, 0};
    tbl[1] = '{1'b0, 4'b0101, 2};
    tbl[2] = '{1'b0, 4'b0101, 0};
    tbl[3] = '{1'b0, 4'b0101, 2};
    tbl[4] = '{1'b1, 4'b1111, 0};
    tbl[5] = '{1'b0, 4'b1111, 1};
    tbl[6] = '{1'b0, 4'b1111, 2};
    tbl[7] = '{1'b0, 4'b1111, 3};
    tbl[8] = '{1'b0, 4'b1111, 0};

    i_rst_n  = 1'b0;
    i_req    = '0;
    i_lock   = '0;
    f_active = 1'b0;
    model_en = 1'b1;
    for (int k = 0; k < 4; k++) dbyte[k] = 8'hA0 + 8'(k);

    // Round-robin grant order with requests held.
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].do_rst) do_reset();
      i_req = tbl[v].req;
      serve("rr", tbl[v].exp_idx, 8'hA0 + 8'(tbl[v].exp_idx), tbl[v].req);
    end

    // Locked owner: 16-byte cap, forced rotation to 2, then 1 resumes.
    do_reset();
    dbyte[1] = 8'h10;
    i_lock   = 4'b0010;
    i_req    = 4'b0110;
    for (int k = 0; k < MB; k++) begin
      wait_ack("burst_ack", a);
      chk("burst_ack", 32'(a), 32'b0010);
      if (k > 0) chk("burst_done_same_cycle", 32'(i_tx_done), 32'd1);
      @(posedge clk);
      #1;
      dbyte[1] = 8'h10 + 8'(k + 1);
      @(negedge clk);
      chk("burst_start", 32'(o_tx_start), 32'd1);
      chk("burst_byte",  32'(o_tx_byte),  32'(8'h10 + 8'(k)));
    end
    serve("burst_rotate", 2, 8'hA2, 4'b0010);
    serve("burst_resume", 1, 8'h20, 4'b0000);
    i_lock = '0;
    wait_idle("burst_idle");

    // Hung transmitter: watchdog fires, sticky flag, arbitration continues.
    do_reset();
    model_en = 1'b0;
    i_req    = 4'b0001;
    serve("to_grant", 0, 8'hA0, 4'b0000);
    repeat (TO) @(negedge clk);
    chk("to_before_limit", 32'(o_timeout), 32'd0);
    chk("to_busy_before",  32'(o_busy),    32'd1);
    @(negedge clk);
    chk("to_fired",        32'(o_timeout), 32'd1);
    chk("to_busy_after",   32'(o_busy),    32'd0);
    model_en = 1'b1;
    i_req    = 4'b0100;
    serve("to_regrant", 2, 8'hA2, 4'b0000);
    wait_idle("to_idle");
    chk("to_sticky", 32'(o_timeout), 32'd1);

    // Transmitter busy holds off grants.
    do_reset();
    f_active = 1'b1;
    i_req    = 4'b1000;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("active_no_ack",   32'(o_ack),      32'd0);
      chk("active_no_start", 32'(o_tx_start), 32'd0);
    end
    @(posedge clk);
    #1;
    f_active = 1'b0;
    @(negedge clk);
    chk("active_release_ack", 32'(o_ack), 32'b1000);
    @(posedge clk);
    #1;
    i_req = '0;
    @(negedge clk);
    chk("active_start", 32'(o_tx_start), 32'd1);
    chk("active_byte",  32'(o_tx_byte),  32'hA3);
    wait_idle("active_idle");

    // Asynchronous reset in the middle of a frame.
    do_reset();
    i_req = 4'b0101;
    serve("midrst_grant", 0, 8'hA0, 4'b0101);
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_start", 32'(o_tx_start), 32'd0);
    chk("midrst_ack",   32'(o_ack),      32'd0);
    chk("midrst_busy",  32'(o_busy),     32'd0);
    chk("midrst_owner", 32'(o_owner),    32'd3);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    serve("midrst_regrant", 0, 8'hA0, 4'b0000);
    wait_idle("midrst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
